multiplicador: RTL and testbench



---
 rtl/multiplicador.sv | 92 +++++++++
 tb/tb_multiplicador.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador.sv
// rtl/multiplicador.sv - sequential 16x16 unsigned shift-and-add multiplier
module multiplicador (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        St,
    input  logic [15:0] Multiplicando,
    input  logic [15:0] Multiplicador,
    output logic        Idle,
    output logic        Done,
    output logic [31:0] Produto
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Initialisers match the reset values so the block works without a Rst pulse.
    state_t      state_q   = S_IDLE;
    logic [15:0] m_q       = '0;
    logic [16:0] a_q       = '0;
    logic [15:0] q_q       = '0;
    logic [3:0]  cnt_q     = '0;
    logic [31:0] produto_q = '0;
    logic        idle_q    = 1'b1;
    logic        done_q    = 1'b0;

    logic [16:0] sum_d;
    logic [16:0] a_d;
    logic [15:0] q_d;

    // One add/shift step: conditional add of M, then 33-bit right shift of {S, Q}.
    // a_q[16] is always zero after a shift, so adding the full register is exact.
    always_comb begin
        sum_d = a_q + {1'b0, (q_q[0] ? m_q : 16'h0000)};
        a_d   = {1'b0, sum_d[16:1]};
        q_d   = {sum_d[0], q_q[15:1]};
    end

    // Control FSM and datapath registers; handshake flags registered with the state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            produto_q <= '0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (St) begin
                        m_q     <= Multiplicando;
                        q_q     <= Multiplicador;
                        a_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                        idle_q  <= 1'b0;
                    end
                end
                S_CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        produto_q <= {a_d[15:0], q_d};
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign Idle    = idle_q;
    assign Done    = done_q;
    assign Produto = produto_q;

endmodule

// File: tb/tb_multiplicador.sv
// tb/tb_multiplicador.sv - self-checking bench for multiplicador
module tb_multiplicador;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        St  = 1'b0;
    logic [15:0] mcand  = '0;
    logic [15:0] mplier = '0;
    logic        Idle;
    logic        Done;
    logic [31:0] Produto;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[8];

    multiplicador dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .St            (St),
        .Multiplicando (mcand),
        .Multiplicador (mplier),
        .Idle          (Idle),
        .Done          (Done),
        .Produto       (Produto)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        return {16'h0000, a} * {16'h0000, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        int lat;
        lat    = -1;
        mcand  = a;
        mplier = b;
        St     = 1'b1;
        tick();
        St = 1'b0;
        check({tag, " idle_after_start"}, {31'b0, Idle}, 32'd0);
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (Done) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd16);
        check({tag, " product"}, Produto, ref_mul(a, b));
        tick();
        check({tag, " idle_return"}, {30'b0, Idle, Done}, 32'b10);
    endtask

    initial begin
        logic [31:0] prev;
        logic [15:0] ops_a[5];
        logic [15:0] ops_b[5];
        int lat;
        int dones;

        vecs[0] = '{16'h07D1, 16'h0FA1, 32'h007A2971};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[3] = '{16'h0001, 16'hABCD, 32'h0000ABCD};
        vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[5] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[6] = '{16'h0100, 16'h0100, 32'h00010000};
        vecs[7] = '{16'h1234, 16'h5678, 32'h06260060};

        #1;
        check("powerup_flags", {30'b0, Idle, Done}, 32'b10);
        check("powerup_produto", Produto, 32'h0);

        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        check("reset_flags", {30'b0, Idle, Done}, 32'b10);
        check("reset_produto", Produto, 32'h0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), Produto, vecs[i].p);
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), $sformatf("rnd%0d", i));
        end

        // St pulses and operand changes during CALC are ignored; Produto holds
        prev   = Produto;
        mcand  = 16'h1234;
        mplier = 16'h5678;
        St     = 1'b1;
        tick();
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            St     = (n <= 10) ? 1'($urandom) : 1'b0;
            mcand  = 16'($urandom);
            mplier = 16'($urandom);
            tick();
            if (Done) begin
                lat = n;
                break;
            end
            check("calc_hold_produto", Produto, prev);
            check("calc_no_idle", {31'b0, Idle}, 32'd0);
        end
        check("calc_change latency", 32'(lat), 32'd16);
        check("calc_change product", Produto, 32'h06260060);
        // St during DONE is neither taken nor queued
        St = 1'b1;
        tick();
        check("done_st_ignored", {30'b0, Idle, Done}, 32'b10);
        St = 1'b0;
        tick();
        check("done_st_not_queued", {30'b0, Idle, Done}, 32'b10);
        check("done_st_produto", Produto, 32'h06260060);

        // Reset at iteration 8 aborts with no Done
        mcand  = 16'hFFFF;
        mplier = 16'hFFFF;
        St     = 1'b1;
        tick();
        St = 1'b0;
        repeat (8) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("midreset_flags", {30'b0, Idle, Done}, 32'b10);
        check("midreset_produto", Produto, 32'h0);
        dones = 0;
        repeat (20) begin
            tick();
            if (Done) dones++;
        end
        check("midreset_no_done", 32'(dones), 32'd0);
        run_op(16'h07D1, 16'h0FA1, "after_reset");

        // St held high: back-to-back operations, each re-latching operands
        for (int k = 0; k < 5; k++) begin
            ops_a[k] = 16'($urandom);
            ops_b[k] = 16'($urandom);
        end
        ops_a[1] = 16'hFFFF;
        ops_b[1] = 16'hFFFF;
        mcand  = ops_a[0];
        mplier = ops_b[0];
        St     = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            mcand  = ops_a[k + 1];
            mplier = ops_b[k + 1];
            lat = -1;
            for (int n = 1; n <= 40; n++) begin
                tick();
                if (Done) begin
                    lat = n;
                    break;
                end
            end
            check($sformatf("b2b%0d latency", k), 32'(lat), 32'd16);
            check($sformatf("b2b%0d product", k), Produto, ref_mul(ops_a[k], ops_b[k]));
            if (k == 3) St = 1'b0;
            tick();
            check($sformatf("b2b%0d idle_up", k), {30'b0, Idle, Done}, 32'b10);
            tick();
            check($sformatf("b2b%0d idle_one_cycle", k), {31'b0, Idle}, (k == 3) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
